// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bus controller: FSM encoding, width helper and the
// default program/VRAM/palette region map.
package mmio_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    // Per-region read latency field width (0..3 wait cycles).
    localparam int unsigned LatW = 2;

    localparam logic [63:0] DefRegionBase  = {16'h4400, 16'h2400, 16'h2000, 16'h0000};
    localparam logic [63:0] DefRegionLimit = {16'h47FF, 16'h43FF, 16'h23FF, 16'h1FFF};
    localparam logic [7:0]  DefRegionLat   = {2'd0, 2'd2, 2'd1, 2'd1};
    localparam logic [3:0]  DefRegionRo    = 4'b1000;
    localparam logic [15:0] DefRegBase     = 16'h4800;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mmio_bus_controller_if.sv
// CPU-side request/response channel of the MMIO bus controller.
interface mmio_bus_controller_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mmio_region_decoder.sv
// Combinational address decoder: local register window plus prioritised device regions.
module mmio_region_decoder
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DefRegionBase,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = DefRegionLimit,
    parameter logic [NUM_REGIONS*LatW-1:0]   REGION_LAT   = DefRegionLat,
    parameter logic [NUM_REGIONS-1:0]        REGION_RO    = DefRegionRo,
    parameter logic [ADDR_W-1:0]             REG_BASE     = DefRegBase,
    localparam int unsigned IdxW    = clog2_min1(NUM_REGIONS),
    localparam int unsigned RegIdxW = clog2_min1(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic               hit,
    output logic [IdxW-1:0]    idx,
    output logic               ro,
    output logic [LatW-1:0]    lat,
    output logic [ADDR_W-1:0]  offset,
    output logic               local_hit,
    output logic [RegIdxW-1:0] local_idx
);

    // One extra bit so addresses below REG_BASE wrap to a value outside the window.
    logic [ADDR_W:0] reg_diff;

    assign reg_diff  = {1'b0, addr} - {1'b0, REG_BASE};
    assign local_hit = reg_diff < (ADDR_W+1)'(NUM_REGS);
    assign local_idx = reg_diff[RegIdxW-1:0];

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        ro     = 1'b0;
        lat    = '0;
        offset = '0;
        for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
            if (addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
                hit    = 1'b1;
                idx    = IdxW'(i);
                ro     = REGION_RO[i];
                lat    = REGION_LAT[i*LatW +: LatW];
                offset = addr - REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/mmio_bus_controller.sv
// Memory-map controller: valid/ready CPU requests, per-region wait states and write
// protection, bus errors for unmapped addresses, and a bank of local control registers.
module mmio_bus_controller
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DefRegionBase,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = DefRegionLimit,
    parameter logic [NUM_REGIONS*LatW-1:0]   REGION_LAT   = DefRegionLat,
    parameter logic [NUM_REGIONS-1:0]        REGION_RO    = DefRegionRo,
    parameter logic [ADDR_W-1:0]             REG_BASE     = DefRegBase,
    parameter int unsigned NUM_REGS    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    mmio_bus_controller_if.slave          bus,
    output logic [NUM_REGIONS-1:0]        dev_en,
    output logic                          dev_we,
    output logic [ADDR_W-1:0]             dev_addr,
    output logic [DATA_W-1:0]             dev_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata,
    output logic [NUM_REGS*DATA_W-1:0]    reg_out
);

    localparam int unsigned IdxW    = clog2_min1(NUM_REGIONS);
    localparam int unsigned RegIdxW = clog2_min1(NUM_REGS);

    logic [1:0]             state_q;
    logic [LatW-1:0]        cnt_q;
    logic [IdxW-1:0]        sel_q;
    logic                   wr_q;
    logic [NUM_REGIONS-1:0] dev_en_q;
    logic                   dev_we_q;
    logic [ADDR_W-1:0]      dev_addr_q;
    logic [DATA_W-1:0]      dev_wdata_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [DATA_W-1:0]      rsp_rdata_q;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];

    logic               hit, ro, local_hit, accept;
    logic [IdxW-1:0]    idx;
    logic [LatW-1:0]    lat;
    logic [ADDR_W-1:0]  offset;
    logic [RegIdxW-1:0] local_idx;
    logic [DATA_W-1:0]  sel_rdata;

    mmio_region_decoder #(
        .ADDR_W       (ADDR_W),
        .NUM_REGIONS  (NUM_REGIONS),
        .NUM_REGS     (NUM_REGS),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .REGION_LAT   (REGION_LAT),
        .REGION_RO    (REGION_RO),
        .REG_BASE     (REG_BASE)
    ) u_decoder (
        .addr      (bus.req_addr),
        .hit       (hit),
        .idx       (idx),
        .ro        (ro),
        .lat       (lat),
        .offset    (offset),
        .local_hit (local_hit),
        .local_idx (local_idx)
    );

    assign bus.req_ready = (state_q == StIdle) || (state_q == StResp);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            if (sel_q == IdxW'(i)) sel_rdata = dev_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= '0;
            wr_q        <= 1'b0;
            dev_en_q    <= '0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else begin
            // Strobes and response fields are single-cycle unless re-asserted below.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            dev_en_q    <= '0;
            dev_we_q    <= 1'b0;
            if (accept) begin
                if (local_hit) begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    if (bus.req_write) regs_q[local_idx] <= bus.req_wdata;
                    else               rsp_rdata_q       <= regs_q[local_idx];
                end else if (hit && !(ro && bus.req_write)) begin
                    state_q     <= StAccess;
                    dev_en_q    <= NUM_REGIONS'(1) << idx;
                    dev_we_q    <= bus.req_write;
                    wr_q        <= bus.req_write;
                    dev_addr_q  <= offset;
                    dev_wdata_q <= bus.req_wdata;
                    cnt_q       <= lat;
                    sel_q       <= idx;
                end else begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                end
            end else begin
                case (state_q)
                    StAccess: begin
                        if (cnt_q == '0) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            if (!wr_q) rsp_rdata_q <= sel_rdata;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                    StWait: begin
                        if (cnt_q == LatW'(1)) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            if (!wr_q) rsp_rdata_q <= sel_rdata;
                        end else begin
                            cnt_q <= cnt_q - LatW'(1);
                        end
                    end
                    StResp:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign dev_en        = dev_en_q;
    assign dev_we        = dev_we_q;
    assign dev_addr      = dev_addr_q;
    assign dev_wdata     = dev_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Directed and randomized bench for mmio_bus_controller against a behavioural memory-map model.
module tb_mmio_bus_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   dev_en;
    logic         dev_we;
    logic [15:0]  dev_addr;
    logic [15:0]  dev_wdata;
    logic [63:0]  dev_rdata;
    logic [127:0] reg_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_base  [4] = '{16'h0000, 16'h2000, 16'h2400, 16'h4400};
    logic [15:0] m_limit [4] = '{16'h1FFF, 16'h23FF, 16'h43FF, 16'h47FF};
    int          m_lat   [4] = '{1, 1, 2, 0};
    bit          m_ro    [4] = '{0, 0, 0, 1};
    logic [15:0] m_regs  [8];

    mmio_bus_controller_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mmio_bus_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dev_en    (dev_en),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .reg_out   (reg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_regs();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = m_regs[i];
        return v;
    endfunction

    // Expected outcome of one transaction, from the address map rules.
    task automatic model(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         output int cyc, output logic err, output logic [15:0] rd,
                         output logic [3:0] en, output logic [15:0] off);
        int found = -1;
        cyc = 0; err = 1'b0; rd = 16'h0; en = 4'h0; off = 16'h0;
        if (a >= 16'h4800 && a <= 16'h4807) begin
            if (wr) m_regs[a - 16'h4800] = wd;
            else    rd = m_regs[a - 16'h4800];
        end else begin
            for (int r = 0; r < 4; r++)
                if (found < 0 && a >= m_base[r] && a <= m_limit[r]) found = r;
            if (found < 0 || (m_ro[found] && wr)) begin
                err = 1'b1;
            end else begin
                cyc = m_lat[found] + 1;
                en  = 4'(1 << found);
                off = a - m_base[found];
                if (!wr) rd = dev_rdata[found*16 +: 16];
            end
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd);
        int          exp_cyc, cyc, pulses;
        logic        exp_err, seen_we;
        logic [15:0] exp_rd, exp_off, seen_addr, seen_wd;
        logic [3:0]  exp_en, seen_en;
        model(wr, a, wd, exp_cyc, exp_err, exp_rd, exp_en, exp_off);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
        check({tag, ".ready"}, 128'(bus.req_ready), 128'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 0; pulses = 0; seen_en = 4'h0; seen_we = 1'b0; seen_addr = 16'h0; seen_wd = 16'h0;
        while (bus.rsp_valid !== 1'b1 && cyc < 8) begin
            if (dev_en != 4'h0) begin
                pulses++; seen_en = dev_en; seen_we = dev_we;
                seen_addr = dev_addr; seen_wd = dev_wdata;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 128'(cyc), 128'(exp_cyc));
        check({tag, ".err"}, 128'(bus.rsp_err), 128'(exp_err));
        check({tag, ".rdata"}, 128'(bus.rsp_rdata), 128'(exp_rd));
        check({tag, ".en_pulses"}, 128'(pulses), 128'(exp_en != 4'h0 ? 1 : 0));
        check({tag, ".dev_en"}, 128'(seen_en), 128'(exp_en));
        check({tag, ".en_in_resp"}, 128'(dev_en), 128'(0));
        if (exp_en != 4'h0) begin
            check({tag, ".dev_addr"}, 128'(seen_addr), 128'(exp_off));
            check({tag, ".dev_we"}, 128'(seen_we), 128'(wr));
            if (wr) check({tag, ".dev_wdata"}, 128'(seen_wd), 128'(wd));
        end
        check({tag, ".reg_out"}, reg_out, model_regs());
        @(posedge clk); #1;
        check({tag, ".rsp_pulse"}, 128'(bus.rsp_valid), 128'(0));
    endtask

    initial begin
        logic [15:0] a;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
        dev_rdata = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        #3;
        check("por.rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("por.ready", 128'(bus.req_ready), 128'(1));
        check("por.reg_out", reg_out, 128'(0));
        @(negedge clk); rst = 1'b1;

        // Leave nonzero state behind so the mid-transaction reset has something to clear.
        do_req("pre_lwr", 1'b1, 16'h4805, 16'h1234);
        do_req("pre_wr", 1'b1, 16'h2010, 16'hBEEF);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h2400;
        bus.req_wdata = 16'h5A5A;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        check("rst.rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("rst.rsp_err", 128'(bus.rsp_err), 128'(0));
        check("rst.rsp_rdata", 128'(bus.rsp_rdata), 128'(0));
        check("rst.dev_en", 128'(dev_en), 128'(0));
        check("rst.dev_we", 128'(dev_we), 128'(0));
        check("rst.dev_addr", 128'(dev_addr), 128'(0));
        check("rst.dev_wdata", 128'(dev_wdata), 128'(0));
        check("rst.reg_out", reg_out, 128'(0));
        @(negedge clk); rst = 1'b1;
        check("rst.ready", 128'(bus.req_ready), 128'(1));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst.no_rsp", 128'(bus.rsp_valid), 128'(0));
        end

        do_req("rd_r1", 1'b0, 16'h2010, 16'h0);
        do_req("rd_r2", 1'b0, 16'h2400, 16'h0);
        do_req("wr_ro", 1'b1, 16'h4401, 16'h7777);
        do_req("wr_miss", 1'b1, 16'h9000, 16'h7777);
        do_req("rd_miss", 1'b0, 16'h9000, 16'h0);
        do_req("lwr", 1'b1, 16'h4802, 16'hABCD);
        check("lwr.slot2", 128'(reg_out[2*16 +: 16]), 128'(16'hABCD));
        do_req("lrd2", 1'b0, 16'h4802, 16'h0);
        do_req("lrd7", 1'b0, 16'h4807, 16'h0);

        // Back-to-back LAT=0 reads with req_valid held through the first RESP cycle.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h4400;
        @(posedge clk); #1;
        check("b2b.en_a", 128'(dev_en), 128'(4'b1000));
        @(posedge clk); #1;
        check("b2b.rsp_a", 128'(bus.rsp_valid), 128'(1));
        check("b2b.data_a", 128'(bus.rsp_rdata), 128'(dev_rdata[63:48]));
        check("b2b.ready_resp", 128'(bus.req_ready), 128'(1));
        check("b2b.en_off_a", 128'(dev_en), 128'(0));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("b2b.en_b", 128'(dev_en), 128'(4'b1000));
        check("b2b.gap", 128'(bus.rsp_valid), 128'(0));
        @(posedge clk); #1;
        check("b2b.rsp_b", 128'(bus.rsp_valid), 128'(1));
        check("b2b.data_b", 128'(bus.rsp_rdata), 128'(dev_rdata[63:48]));
        @(posedge clk); #1;
        check("b2b.end", 128'(bus.rsp_valid | (|dev_en)), 128'(0));

        for (int t = 0; t < 40; t++) begin
            int c;
            c = $urandom_range(0, 5);
            dev_rdata = {$urandom, $urandom};
            if (c < 4)       a = m_base[c] + 16'($urandom_range(0, int'(m_limit[c] - m_base[c])));
            else if (c == 4) a = 16'h4800 + 16'($urandom_range(0, 7));
            else             a = 16'h4808 + 16'($urandom_range(0, 16'hFFFF - 16'h4808));
            do_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
